// File: rtl/noc_arb_pkg.sv
// noc_arb_pkg
// Shared definitions for the NoC output-port arbiter slice.
//   ADDR_W      : width of a next-hop address
//   PORT_N..L   : next-hop port encodings
//   arb_state_t : arbiter lock state (IDLE / LOCKED)
package noc_arb_pkg;

  localparam int ADDR_W = 3;

  localparam logic [ADDR_W-1:0] PORT_N = 3'd0;
  localparam logic [ADDR_W-1:0] PORT_S = 3'd1;
  localparam logic [ADDR_W-1:0] PORT_W = 3'd2;
  localparam logic [ADDR_W-1:0] PORT_E = 3'd3;
  localparam logic [ADDR_W-1:0] PORT_L = 3'd4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational rotating-priority picker: the winner is the first set
// request at or after i_ptr, scanning upward and wrapping to 0.
// Ports:
//   i_req    : request vector
//   i_ptr    : index with highest priority this cycle
//   o_onehot : one-hot winner (all zero when no request)
//   o_idx    : binary index of winner (0 when no request)
//   o_any    : at least one request present
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic w_found;

  // scan NUM_REQ candidates starting at the pointer; first hit wins
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int cand;
      cand = (int'(i_ptr) + k) % NUM_REQ;
      if (!w_found && i_req[cand]) begin
        o_onehot[cand] = 1'b1;
        o_idx          = IDX_W'(cand);
        w_found        = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/rr_output_arbiter.sv
// rr_output_arbiter
// Packet-locking round-robin arbiter for one NoC output port. A requester
// whose next-hop address equals PORT_ID competes; the winner keeps the
// output until its tail flit transfers, then the round-robin pointer moves
// to the next index.
// Optional feature: define RR_ARB_WATCHDOG_EN to add a stall watchdog that
// force-releases a lock after WDOG_CYCLES locked cycles without a transfer.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   nexthop_addr_i  : per-requester next-hop address (slice i = requester i)
//   flit_valid_i    : requester i presents a flit
//   flit_tail_i     : presented flit is a packet tail
//   out_ready_i     : downstream accepts a flit this cycle
//   grant_o         : registered one-hot grant
//   grant_idx_o     : binary index of the holder (crossbar select)
//   grant_valid_o   : lock held
//   xfer_o          : flit transferred this cycle (combinational)
//   wdog_o          : one-cycle pulse on watchdog release
module rr_output_arbiter
  import noc_arb_pkg::*;
#(
  parameter  int                NUM_REQ     = 4,
  parameter  logic [ADDR_W-1:0] PORT_ID     = PORT_E,
  parameter  int                WDOG_CYCLES = 64,
  localparam int                IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ*ADDR_W-1:0] nexthop_addr_i,
  input  logic [NUM_REQ-1:0]        flit_valid_i,
  input  logic [NUM_REQ-1:0]        flit_tail_i,
  input  logic                      out_ready_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic [IDX_W-1:0]          grant_idx_o,
  output logic                      grant_valid_o,
  output logic                      xfer_o,
  output logic                      wdog_o
);

  arb_state_t         r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] r_grant;
  logic [IDX_W-1:0]   r_grant_idx;
  logic               r_grant_valid;

  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_pick_onehot;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_any;
  logic               w_xfer;
  logic               w_release;
  logic               w_wdog_fire;
  logic [IDX_W-1:0]   w_ptr_next;

  // a requester competes only when its flit targets this output
  always_comb begin
    w_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_req[i] = flit_valid_i[i] & (nexthop_addr_i[i*ADDR_W +: ADDR_W] == PORT_ID);
    end
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .i_req    (w_req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  // while locked only the holder's valid matters; its address is ignored
  assign w_xfer     = r_grant_valid & flit_valid_i[r_grant_idx] & out_ready_i;
  assign w_release  = (w_xfer & flit_tail_i[r_grant_idx]) | w_wdog_fire;
  assign w_ptr_next = (r_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_idx + IDX_W'(1);

`ifdef RR_ARB_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] r_wdog_cnt;
  logic              r_wdog;

  // counter holds the number of stalled locked cycles already seen, so the
  // WDOG_CYCLES-th stalled cycle is the one that fires
  assign w_wdog_fire = (r_state == LOCKED) & ~w_xfer &
                       (r_wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

  // stall counter: counts locked cycles without a transfer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wdog_cnt <= '0;
    end else if ((r_state == LOCKED) && !w_xfer && !w_wdog_fire) begin
      r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
    end else begin
      r_wdog_cnt <= '0;
    end
  end

  // one-cycle pulse following a forced release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wdog <= 1'b0;
    end else begin
      r_wdog <= w_wdog_fire;
    end
  end

  assign wdog_o = r_wdog;
`else
  assign w_wdog_fire = 1'b0;
  assign wdog_o      = 1'b0;

  // WDOG_CYCLES has no effect without the watchdog; nothing is built from it
  if (WDOG_CYCLES < 1) begin : g_wdog_cycles_unused
  end
`endif

  // lock FSM: grant on IDLE, hold until tail transfer (or watchdog), then
  // advance the pointer past the released holder
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_grant       <= '0;
      r_grant_idx   <= '0;
      r_grant_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            r_state       <= LOCKED;
            r_grant       <= w_pick_onehot;
            r_grant_idx   <= w_pick_idx;
            r_grant_valid <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        LOCKED: begin
          if (w_release) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_ptr         <= w_ptr_next;
          end else begin
            r_state <= LOCKED;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_grant       <= '0;
          r_grant_idx   <= '0;
          r_grant_valid <= 1'b0;
        end
      endcase
    end
  end

  assign grant_o       = r_grant;
  assign grant_idx_o   = r_grant_idx;
  assign grant_valid_o = r_grant_valid;
  assign xfer_o        = w_xfer;

endmodule

// File: tb/tb_rr_output_arbiter.sv
// tb_rr_output_arbiter
// Directed scenarios followed by random traffic, every cycle compared with
// a reference model that tracks only "who holds the port" and "where the
// round-robin search starts".
module tb_rr_output_arbiter;
  import noc_arb_pkg::*;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [N*ADDR_W-1:0] addr;
  logic [N-1:0]      vld;
  logic [N-1:0]      tl;
  logic              rdy;
  logic [N-1:0]      grant_o;
  logic [1:0]        grant_idx_o;
  logic              grant_valid_o;
  logic              xfer_o;
  logic              wdog_o;

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model: holder (-1 = nobody) and search start
  int m_holder = -1;
  int m_ptr    = 0;

  int grant_log[$];
  int xfer_cnt;

  logic [N*ADDR_W-1:0] all_e;
  logic [N*ADDR_W-1:0] mix_addr;

  always #5 clk = ~clk;

  rr_output_arbiter #(
    .NUM_REQ     (N),
    .PORT_ID     (PORT_E),
    .WDOG_CYCLES (64)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .nexthop_addr_i (addr),
    .flit_valid_i   (vld),
    .flit_tail_i    (tl),
    .out_ready_i    (rdy),
    .grant_o        (grant_o),
    .grant_idx_o    (grant_idx_o),
    .grant_valid_o  (grant_valid_o),
    .xfer_o         (xfer_o),
    .wdog_o         (wdog_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock cycle: drive, compare against the model, then advance the model
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] t,
                      input logic [N*ADDR_W-1:0] a, input logic r);
    logic       e_valid;
    logic [N-1:0] e_grant;
    logic       e_xfer;
    bit         found;
    @(negedge clk);
    vld  = v;
    tl   = t;
    addr = a;
    rdy  = r;
    #1;
    e_valid = (m_holder >= 0);
    e_grant = e_valid ? (4'b0001 << m_holder) : 4'b0000;
    e_xfer  = e_valid ? (v[m_holder] & r) : 1'b0;
    chk("grant_valid", 32'(grant_valid_o), 32'(e_valid));
    chk("grant", 32'(grant_o), 32'(e_grant));
    if (e_valid) chk("grant_idx", 32'(grant_idx_o), 32'(m_holder));
    chk("xfer", 32'(xfer_o), 32'(e_xfer));
    chk("wdog", 32'(wdog_o), 32'd0);
    if (grant_valid_o) grant_log.push_back(int'(grant_idx_o));
    if (xfer_o) xfer_cnt++;
    @(posedge clk);
    if (m_holder < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!found && v[c] && (a[c*ADDR_W +: ADDR_W] == PORT_E)) begin
          m_holder = c;
          found    = 1'b1;
        end
      end
    end else if (e_xfer && t[m_holder]) begin
      m_ptr    = (m_holder + 1) % N;
      m_holder = -1;
    end
  endtask

  initial begin
    all_e    = {PORT_E, PORT_E, PORT_E, PORT_E};
    mix_addr = {PORT_E, PORT_N, PORT_E, PORT_E};
    reset = 1'b0;
    vld   = '0;
    tl    = '0;
    rdy   = 1'b0;
    addr  = all_e;
    #12;
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_valid", 32'(grant_valid_o), 32'd0);
    chk("rst_idx", 32'(grant_idx_o), 32'd0);
    chk("rst_wdog", 32'(wdog_o), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // all four request single-flit packets: 0,1,2,3,0 with idle gaps
    grant_log.delete();
    repeat (10) step(4'hF, 4'hF, all_e, 1'b1);
    chk("rr_count", 32'(grant_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      chk("rr_order", 32'(grant_log[i]), 32'(i % 4));

    // requester 1: 3-flit packet, bubble, 5-cycle stall on flit 2
    grant_log.delete();
    xfer_cnt = 0;
    step(4'b0010, 4'b0000, all_e, 1'b1);
    step(4'b0010, 4'b0000, all_e, 1'b1);
    step(4'b0000, 4'b0000, all_e, 1'b1);
    repeat (5) step(4'b0010, 4'b0000, all_e, 1'b0);
    step(4'b0010, 4'b0000, all_e, 1'b1);
    step(4'b0010, 4'b0010, all_e, 1'b1);
    step(4'b0000, 4'b0000, all_e, 1'b1);
    chk("hold_cycles", 32'(grant_log.size()), 32'd9);
    chk("hold_xfers", 32'(xfer_cnt), 32'd3);
    grant_log.delete();
    step(4'hF, 4'hF, all_e, 1'b1);
    step(4'b0100, 4'b0100, all_e, 1'b1);
    chk("ptr_after_1", 32'(grant_log[0]), 32'd2);

    // pointer at 3, requests 0 and 2: wraps to 0
    grant_log.delete();
    step(4'b0101, 4'b0101, all_e, 1'b1);
    step(4'b0101, 4'b0101, all_e, 1'b1);
    chk("wrap", 32'(grant_log[0]), 32'd0);

    // requester 2 aims at PORT_N and must never win
    grant_log.delete();
    repeat (8) step(4'b1100, 4'b1100, mix_addr, 1'b1);
    chk("other_port_cnt", 32'(grant_log.size()), 32'd4);
    foreach (grant_log[i]) chk("other_port_idx", 32'(grant_log[i]), 32'd3);

    // move ptr to 2, lock requester 2, then reset mid-packet
    step(4'b0010, 4'b0010, all_e, 1'b1);
    step(4'b0010, 4'b0010, all_e, 1'b1);
    step(4'b0100, 4'b0000, all_e, 1'b1);
    step(4'b0100, 4'b0000, all_e, 1'b1);
    chk("pre_rst_idx", 32'(grant_idx_o), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(grant_o), 32'd0);
    chk("mid_rst_valid", 32'(grant_valid_o), 32'd0);
    m_holder = -1;
    m_ptr    = 0;
    vld      = '0;
    tl       = '0;
    @(negedge clk);
    reset = 1'b1;
    grant_log.delete();
    step(4'hF, 4'hF, all_e, 1'b1);
    step(4'hF, 4'hF, all_e, 1'b1);
    chk("post_rst_first", 32'(grant_log[0]), 32'd0);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [N*ADDR_W-1:0] ra;
      for (int s = 0; s < N; s++) begin
        ra[s*ADDR_W +: ADDR_W] = ($urandom % 3 == 0) ? ADDR_W'($urandom) : PORT_E;
      end
      step(N'($urandom), N'($urandom), ra, ($urandom % 4) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rr_output_arbiter.md
RR_OUTPUT_ARBITER -- requirements
Module: rr_output_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesting input ports (2..8).
REQ-002 Parameter PORT_ID, default noc_arb_pkg::PORT_E, next-hop address this arbiter owns.
REQ-003 Parameter WDOG_CYCLES, default 64, stall limit for the lock watchdog (macro-dependent).
REQ-004 clk  input  1  rising-edge clock; one clock; reset is asynchronous and active-low.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 nexthop_addr_i  input  NUM_REQ*ADDR_W  per-requester next-hop address; slice i = requester i.
REQ-007 flit_valid_i  input  NUM_REQ  requester i presents a flit.
REQ-008 flit_tail_i  input  NUM_REQ  presented flit is the packet tail.
REQ-009 out_ready_i  input  1  downstream can accept a flit this cycle.
REQ-010 grant_o  output  NUM_REQ  registered one-hot grant.
REQ-011 grant_idx_o  output  $clog2(NUM_REQ)  binary index of holder; crossbar select.
REQ-012 grant_valid_o  output  1  lock held.
REQ-013 xfer_o  output  1  combinational: flit transferred this cycle.
REQ-014 wdog_o  output  1  one-cycle pulse on forced release (0 when macro absent).

Function
REQ-015 Request i SHALL be flit_valid_i[i] & (nexthop slice i == PORT_ID).
REQ-016 FSM SHALL have states IDLE and LOCKED.
REQ-017 In IDLE with any request, the winner SHALL be the first requester at or after ptr, scanning upward with wrap at NUM_REQ-1 to 0; next cycle state=LOCKED, grant_o/grant_idx_o/grant_valid_o reflect winner (latency 1).
REQ-018 In IDLE with no request, state, ptr and outputs SHALL hold; grant_o=0.
REQ-019 xfer_o SHALL equal grant_valid_o & flit_valid_i[grant_idx_o] & out_ready_i; address of non-head flits SHALL be ignored while LOCKED.
REQ-020 In LOCKED, grant SHALL hold until xfer_o with flit_tail_i[grant_idx_o]=1; next cycle state=IDLE, grant cleared, ptr=(grant_idx_o+1) mod NUM_REQ.
REQ-021 A released requester SHALL NOT be re-granted in the release cycle; at least one IDLE cycle between packets.
REQ-022 Single-flit packet (head=tail) SHALL lock for exactly one cycle if out_ready_i=1.
REQ-023 Requests from other ports arriving while LOCKED SHALL NOT alter grant or ptr.
REQ-024 out_ready_i=0 SHALL stall without releasing; flit_valid_i deassertion by holder SHALL not release.
REQ-025 ptr SHALL update only on release, never on grant.

Reset
REQ-026 On reset low, asynchronously: state=IDLE, ptr=0, grant_o=0, grant_idx_o=0, grant_valid_o=0, wdog_o=0, watchdog counter=0.
REQ-027 Reset mid-packet SHALL drop the lock immediately; first grant after release follows ptr=0.

Configuration
REQ-028 Macro RR_ARB_WATCHDOG_EN: when defined, a counter SHALL count LOCKED cycles without xfer_o, clear on xfer_o, and at WDOG_CYCLES force release as in REQ-020 with wdog_o pulsed one cycle.
REQ-029 Without RR_ARB_WATCHDOG_EN: no counter logic, wdog_o tied 0, lock held indefinitely.

Structure
REQ-030 Package noc_arb_pkg SHALL hold ADDR_W=3, port encodings PORT_N/S/W/E/L, and the arb_state_t enum.
REQ-031 Combinational sub-module rr_pick (request vector, ptr -> one-hot winner, index, any) SHALL implement the rotating scan.

Verification (NUM_REQ=4, PORT_ID=PORT_E)
REQ-032 Reset, all four request E single-flit, out_ready=1 -> grants 0,1,2,3,0 each one cycle, one IDLE cycle between.
REQ-033 Req1 3-flit packet, out_ready low on flit 2 for 5 cycles -> grant_idx=1 held 9 cycles, xfer_o=3 pulses, then ptr=2.
REQ-034 ptr=3, requests 0 and 2 -> requester 0 granted (wrap).
REQ-035 Requester 2 addresses PORT_N -> never granted; requester 3 addressing E granted.
REQ-036 reset low during LOCKED with grant 2 -> grant_o=0 same edge-free, next grant from ptr=0.
REQ-037 With RR_ARB_WATCHDOG_EN, WDOG_CYCLES=8, holder stalls -> release after 8 cycles, wdog_o one pulse, ptr=holder+1.
